// File: rtl/balance_manager.sv
// -----------------------------------------------------------------------------
// balance_manager
//
// Purpose:
//   Owns the customer balance of the vending machine. It accumulates inserted
//   coins and deducts the cost of items reported by the downstream dispenser.
//   It also runs an inactivity timer. When the timer expires, or when the
//   customer asks for change, it pays the balance back one coin per cycle,
//   always using the largest coin that still fits.
//
// Ports:
//   clk               system clock, rising edge
//   reset             synchronous, active-high reset
//   i_input_coin      one bit per coin type (100, 500, 1000); several may be set
//   i_output_item     item(s) dispensed this cycle, from the dispenser
//   i_item_cost       total cost of i_output_item; zero when nothing dispensed
//   i_trigger_return  customer requests change
//   balance           current balance, registered
//   o_available_item  bit i set when item i is affordable and not returning
//   o_return_coin     one-hot coin ejected this cycle, registered
//   o_busy            high while change is being returned
// -----------------------------------------------------------------------------
module balance_manager #(
  parameter int NUM_ITEMS   = 4,
  parameter int NUM_COINS   = 3,
  parameter int TOTAL_BITS  = 31,
  parameter int WAIT_TIME   = 10,
  parameter int MAX_BALANCE = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_COINS-1:0]  i_input_coin,
  input  logic [NUM_ITEMS-1:0]  i_output_item,
  input  logic [TOTAL_BITS:0]   i_item_cost,
  input  logic                  i_trigger_return,
  output logic [TOTAL_BITS:0]   balance,
  output logic [NUM_ITEMS-1:0]  o_available_item,
  output logic [NUM_COINS-1:0]  o_return_coin,
  output logic                  o_busy
);

  localparam int BW = TOTAL_BITS + 1;
  localparam int TW = (WAIT_TIME > 0) ? $clog2(WAIT_TIME + 1) : 1;

  localparam logic [BW-1:0] MAX_BAL   = BW'(MAX_BALANCE);
  localparam logic [TW-1:0] WAIT_LOAD = TW'(WAIT_TIME);

  typedef enum logic [1:0] {
    S_IDLE,    // balance is zero
    S_ACTIVE,  // balance is positive and the inactivity timer is running
    S_RETURN   // change is being ejected
  } state_t;

  // Coin values, in ascending order of index.
  function automatic logic [BW-1:0] coin_value(input int idx);
    case (idx)
      0:       return BW'(100);
      1:       return BW'(500);
      2:       return BW'(1000);
      default: return '0;
    endcase
  endfunction

  // Item prices. An unknown index gets an unreachable price, so it is never
  // offered.
  function automatic logic [BW-1:0] item_price(input int idx);
    case (idx)
      0:       return BW'(400);
      1:       return BW'(500);
      2:       return BW'(1000);
      3:       return BW'(2000);
      default: return '1;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [BW-1:0]         r_balance;
  logic [TW-1:0]         r_timer;
  logic [NUM_COINS-1:0]  r_return_coin;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t                w_state_nxt;
  logic [BW-1:0]         w_balance_nxt;
  logic [TW-1:0]         w_timer_nxt;
  logic [NUM_COINS-1:0]  w_return_coin_nxt;

  logic [BW-1:0]         w_coin_sum;
  logic                  w_coin_fits;
  logic [BW-1:0]         w_bal_applied;
  logic                  w_event;
  logic [BW-1:0]         w_change_val;
  logic [NUM_COINS-1:0]  w_change_onehot;
  logic [NUM_ITEMS-1:0]  w_available;

  // Total value of the coins inserted this cycle.
  // NOTE: every variable written in an always_comb block gets a default at the
  // top of the block. A path that leaves it unassigned would infer a latch.
  always_comb begin
    w_coin_sum = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (i_input_coin[i]) begin
        w_coin_sum = w_coin_sum + coin_value(i);
      end
    end
  end

  // A batch of coins that would push the balance past the ceiling is refused
  // as a whole. The dispensed cost is still deducted in the same cycle.
  assign w_coin_fits   = (r_balance + w_coin_sum) <= MAX_BAL;
  assign w_bal_applied = r_balance + (w_coin_fits ? w_coin_sum : '0) - i_item_cost;

  // Rejected coins still count as customer activity.
  assign w_event = (|i_input_coin) || (|i_output_item);

  // Largest coin that does not exceed the balance. The coin values are
  // ascending, so the last match in the loop is the largest one.
  always_comb begin
    w_change_val    = '0;
    w_change_onehot = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if ((coin_value(i) != '0) && (coin_value(i) <= r_balance)) begin
        w_change_val    = coin_value(i);
        w_change_onehot = '0;
        w_change_onehot[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_balance_nxt     = r_balance;
    w_timer_nxt       = r_timer;
    w_return_coin_nxt = '0;

    case (r_state)
      S_IDLE: begin
        // A change request has no effect while the balance is empty.
        w_balance_nxt = w_bal_applied;
        if (w_bal_applied != '0) begin
          w_state_nxt = S_ACTIVE;
          w_timer_nxt = WAIT_LOAD;
        end
      end

      S_ACTIVE: begin
        w_balance_nxt = w_bal_applied;
        if (i_trigger_return) begin
          // This has priority over a timeout and over an emptied balance.
          // Any coins or dispense on this edge are still applied first.
          w_state_nxt = S_RETURN;
          w_timer_nxt = '0;
        end else if (w_bal_applied == '0) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end else if (w_event) begin
          w_timer_nxt = WAIT_LOAD;
        end else if (r_timer != '0) begin
          w_timer_nxt = r_timer - TW'(1);
        end else begin
          // The timer has already reached zero with no activity, so this is
          // the (WAIT_TIME+1)-th quiet edge.
          w_state_nxt = S_RETURN;
        end
      end

      S_RETURN: begin
        // All customer and dispenser inputs are ignored here.
        if (r_balance != '0) begin
          w_balance_nxt     = r_balance - w_change_val;
          w_return_coin_nxt = w_change_onehot;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. All registers then
  // update together from their pre-edge values, whatever order they are
  // written in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_balance     <= '0;
      r_timer       <= '0;
      r_return_coin <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_balance     <= w_balance_nxt;
      r_timer       <= w_timer_nxt;
      r_return_coin <= w_return_coin_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_available = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      w_available[i] = (item_price(i) <= r_balance) && (r_state != S_RETURN);
    end
  end

  assign balance          = r_balance;
  assign o_available_item = w_available;
  assign o_return_coin    = r_return_coin;
  assign o_busy           = (r_state == S_RETURN);

endmodule

// File: tb/tb_balance_manager.sv
// -----------------------------------------------------------------------------
// tb_balance_manager
//
// Purpose:
//   Self-checking bench for balance_manager. It first applies a table of
//   directed vectors with fixed expected outputs. It then runs a few
//   hand-written corner sequences and a randomized run. Both of those are
//   checked against a transaction-level model of the customer's money: the
//   model counts quiet cycles and plans the change as a greedy list of coins.
// -----------------------------------------------------------------------------
module tb_balance_manager;

  localparam int WAIT_TIME   = 10;
  localparam int MAX_BALANCE = 100000;

  localparam int M_IDLE = 0;
  localparam int M_ACT  = 1;
  localparam int M_RET  = 2;

  logic        clk;
  logic        rst;
  logic [2:0]  coin;
  logic [3:0]  item;
  logic [31:0] cost;
  logic        trig;

  logic [31:0] dut_balance;
  logic [3:0]  dut_avail;
  logic [2:0]  dut_ret;
  logic        dut_busy;

  int n_checks = 0;
  int n_errors = 0;

  int prices [4] = '{400, 500, 1000, 2000};

  // Model state.
  int  m_bal;
  int  m_mode;
  int  m_quiet;
  int  m_q[$];
  logic [2:0] m_ret;

  balance_manager #(
    .NUM_ITEMS  (4),
    .NUM_COINS  (3),
    .TOTAL_BITS (31),
    .WAIT_TIME  (WAIT_TIME),
    .MAX_BALANCE(MAX_BALANCE)
  ) dut (
    .clk              (clk),
    .reset            (rst),
    .i_input_coin     (coin),
    .i_output_item    (item),
    .i_item_cost      (cost),
    .i_trigger_return (trig),
    .balance          (dut_balance),
    .o_available_item (dut_avail),
    .o_return_coin    (dut_ret),
    .o_busy           (dut_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Greedy change plan: as many 1000s as fit, then 500s, then 100s.
  task automatic plan_change();
    int rem;
    rem = m_bal;
    m_q.delete();
    while (rem >= 1000) begin m_q.push_back(1000); rem -= 1000; end
    while (rem >= 500)  begin m_q.push_back(500);  rem -= 500;  end
    while (rem >= 100)  begin m_q.push_back(100);  rem -= 100;  end
    m_mode = M_RET;
  endtask

  function automatic logic [2:0] coin_onehot(input int v);
    if (v == 1000) return 3'b100;
    if (v == 500)  return 3'b010;
    if (v == 100)  return 3'b001;
    return 3'b000;
  endfunction

  // Advances the model by one clock edge, using the inputs about to be sampled.
  task automatic model_edge();
    int sum;
    int nb;
    int v;
    bit ev;
    m_ret = 3'b000;
    if (rst) begin
      m_bal = 0; m_mode = M_IDLE; m_quiet = 0; m_q.delete();
      return;
    end
    if (m_mode == M_RET) begin
      if (m_q.size() > 0) begin
        v = m_q.pop_front();
        m_bal -= v;
        m_ret = coin_onehot(v);
      end else begin
        m_mode = M_IDLE;
      end
      return;
    end
    sum = (coin[0] ? 100 : 0) + (coin[1] ? 500 : 0) + (coin[2] ? 1000 : 0);
    if (m_bal + sum > MAX_BALANCE) sum = 0;
    nb = m_bal + sum - int'(cost);
    ev = (coin != 0) || (item != 0);
    m_bal = nb;
    if (m_mode == M_IDLE) begin
      if (nb > 0) begin m_mode = M_ACT; m_quiet = 0; end
    end else begin
      if (trig)           plan_change();
      else if (nb == 0)   m_mode = M_IDLE;
      else if (ev)        m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet > WAIT_TIME) plan_change();
      end
    end
  endtask

  // One clock edge, with a full comparison against the model afterwards.
  task automatic step();
    logic [3:0] ea;
    model_edge();
    @(posedge clk);
    #1;
    ea = '0;
    for (int k = 0; k < 4; k++)
      if (m_mode != M_RET && prices[k] <= m_bal) ea[k] = 1'b1;
    check("model.balance", dut_balance, m_bal);
    check("model.available", {28'd0, dut_avail}, {28'd0, ea});
    check("model.return_coin", {29'd0, dut_ret}, {29'd0, m_ret});
    check("model.busy", {31'd0, dut_busy}, (m_mode == M_RET) ? 32'd1 : 32'd0);
  endtask

  task automatic idle_inputs();
    rst = 0; coin = 0; item = 0; cost = 0; trig = 0;
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  coin;
    logic [3:0]  item;
    logic [31:0] cost;
    logic        trig;
    logic [31:0] e_bal;
    logic [3:0]  e_avail;
    logic [2:0]  e_ret;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] c, input logic [3:0] it,
                     input int cs, input logic tr, input int eb,
                     input logic [3:0] ea, input logic [2:0] er, input logic ebz);
    vec_t v;
    v.rst = r; v.coin = c; v.item = it; v.cost = cs; v.trig = tr;
    v.e_bal = eb; v.e_avail = ea; v.e_ret = er; v.e_busy = ebz;
    vecs.push_back(v);
  endtask

  int k;

  initial begin
    idle_inputs();
    m_bal = 0; m_mode = M_IDLE; m_quiet = 0; m_ret = 0;

    // ---------------- Directed table ----------------
    //   rst coin    item     cost trig  bal   avail    ret     busy
    add(1, 3'b000, 4'b0000,    0, 0,     0, 4'b0000, 3'b000, 0);
    add(0, 3'b100, 4'b0000,    0, 0,  1000, 4'b0111, 3'b000, 0);
    add(0, 3'b010, 4'b0000,    0, 0,  1500, 4'b0111, 3'b000, 0);
    add(0, 3'b000, 4'b0010,  500, 0,  1000, 4'b0111, 3'b000, 0);
    add(0, 3'b010, 4'b0000,    0, 0,  1500, 4'b0111, 3'b000, 0);
    add(0, 3'b001, 4'b0000,    0, 0,  1600, 4'b0111, 3'b000, 0);
    add(0, 3'b000, 4'b0000,    0, 1,  1600, 4'b0000, 3'b000, 1);
    add(0, 3'b000, 4'b0000,    0, 0,   600, 4'b0000, 3'b100, 1);
    add(0, 3'b000, 4'b0000,    0, 0,   100, 4'b0000, 3'b010, 1);
    add(0, 3'b000, 4'b0000,    0, 0,     0, 4'b0000, 3'b001, 1);
    add(0, 3'b000, 4'b0000,    0, 0,     0, 4'b0000, 3'b000, 0);
    add(0, 3'b001, 4'b0000,    0, 0,   100, 4'b0000, 3'b000, 0);
    for (int i = 0; i < WAIT_TIME; i++)
      add(0, 3'b000, 4'b0000,  0, 0,   100, 4'b0000, 3'b000, 0);
    add(0, 3'b000, 4'b0000,    0, 0,   100, 4'b0000, 3'b000, 1);
    add(0, 3'b000, 4'b0000,    0, 0,     0, 4'b0000, 3'b001, 1);
    add(0, 3'b000, 4'b0000,    0, 0,     0, 4'b0000, 3'b000, 0);
    add(0, 3'b001, 4'b0000,    0, 0,   100, 4'b0000, 3'b000, 0);
    add(0, 3'b001, 4'b0000,    0, 0,   200, 4'b0000, 3'b000, 0);
    add(0, 3'b001, 4'b0000,    0, 0,   300, 4'b0000, 3'b000, 0);
    add(0, 3'b001, 4'b0000,    0, 0,   400, 4'b0001, 3'b000, 0);
    add(0, 3'b010, 4'b0001,  400, 0,   500, 4'b0011, 3'b000, 0);
    add(0, 3'b000, 4'b0000,    0, 1,   500, 4'b0000, 3'b000, 1);
    add(0, 3'b100, 4'b0000,    0, 0,     0, 4'b0000, 3'b010, 1);
    add(0, 3'b100, 4'b0000,    0, 0,     0, 4'b0000, 3'b000, 0);
    add(0, 3'b100, 4'b0000,    0, 0,  1000, 4'b0111, 3'b000, 0);
    add(0, 3'b010, 4'b0000,    0, 0,  1500, 4'b0111, 3'b000, 0);
    add(0, 3'b000, 4'b0000,    0, 1,  1500, 4'b0000, 3'b000, 1);
    add(0, 3'b000, 4'b0000,    0, 0,   500, 4'b0000, 3'b100, 1);
    add(1, 3'b000, 4'b0000,    0, 0,     0, 4'b0000, 3'b000, 0);
    add(0, 3'b000, 4'b0000,    0, 0,     0, 4'b0000, 3'b000, 0);
    add(0, 3'b000, 4'b0000,    0, 1,     0, 4'b0000, 3'b000, 0);

    for (int t = 0; t < vecs.size(); t++) begin
      rst = vecs[t].rst; coin = vecs[t].coin; item = vecs[t].item;
      cost = vecs[t].cost; trig = vecs[t].trig;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.balance", t), dut_balance, vecs[t].e_bal);
      check($sformatf("vec%0d.available", t), {28'd0, dut_avail}, {28'd0, vecs[t].e_avail});
      check($sformatf("vec%0d.return_coin", t), {29'd0, dut_ret}, {29'd0, vecs[t].e_ret});
      check($sformatf("vec%0d.busy", t), {31'd0, dut_busy}, {31'd0, vecs[t].e_busy});
    end

    // ---------------- Balance ceiling ----------------
    idle_inputs(); rst = 1; step(); rst = 0;
    coin = 3'b100;
    repeat (100) step();
    check("max.fill", dut_balance, 32'd100000);
    coin = 3'b001; step();
    check("max.reject", dut_balance, 32'd100000);
    coin = 3'b100; item = 4'b1000; cost = 2000; step();
    check("max.reject_with_cost", dut_balance, 32'd98000);
    coin = 3'b001; item = 0; cost = 0; step();
    check("max.accept_after", dut_balance, 32'd98100);
    check("max.available", {28'd0, dut_avail}, 32'hF);

    // ---------------- A dispense reloads the timer ----------------
    idle_inputs(); rst = 1; step(); rst = 0;
    coin = 3'b100; step(); coin = 0;
    repeat (9) step();
    item = 4'b0001; cost = 400; step(); item = 0; cost = 0;
    check("reload.balance", dut_balance, 32'd600);
    repeat (WAIT_TIME) step();
    check("reload.not_busy", {31'd0, dut_busy}, 32'd0);
    step();
    check("reload.busy", {31'd0, dut_busy}, 32'd1);
    repeat (4) step();
    check("reload.drained", dut_balance, 32'd0);

    // ---------------- Change request that empties the balance ----------------
    idle_inputs(); rst = 1; step(); rst = 0;
    coin = 3'b001; repeat (4) step(); coin = 0;
    item = 4'b0001; cost = 400; trig = 1; step();
    idle_inputs();
    check("zero_return.busy", {31'd0, dut_busy}, 32'd1);
    check("zero_return.balance", dut_balance, 32'd0);
    step();
    check("zero_return.idle", {31'd0, dut_busy}, 32'd0);

    // ---------------- Randomized run against the model ----------------
    idle_inputs(); rst = 1; step();
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) coin = 3'($urandom_range(1, 7));
      if (m_mode != M_RET) begin
        if ($urandom_range(0, 5) == 0) begin
          k = $urandom_range(0, 3);
          if (prices[k] <= m_bal) begin
            item = 4'b0001 << k;
            cost = prices[k];
          end
        end
      end else begin
        item = 4'($urandom);
      end
      if ($urandom_range(0, 39) == 0) trig = 1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
